// File: rtl/axi_defs.sv
// rtl/axi_defs.sv - shared AXI response/burst codes and responder state encodings
package axi_defs;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_CAP  = 3'd1;
    localparam logic [2:0] ST_RD_RESP = 3'd2;
    localparam logic [2:0] ST_WR_DATA = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_STALL   = 3'd5;

    // Decode error outranks slave error, which outranks OKAY.
    function automatic logic [1:0] resp_of(input logic dec, input logic slv);
        if (dec) return AXI_RESP_DECERR;
        if (slv) return AXI_RESP_SLVERR;
        return AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_resp_stall_ctr.sv
// rtl/axi_resp_stall_ctr.sv - wait-cycle counter placed in front of each rvalid/bvalid rise
// Ports: aclk, aresetn (sync, active-low), load (arm with CYCLES), en (count one cycle),
//        done (current cycle is the last wait cycle).
module axi_resp_stall_ctr #(
    parameter int CYCLES = 3
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic load,
    input  logic en,
    output logic done
);
    localparam int W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(CYCLES);
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // A count of 1 (or a zero-length stall) means this is the final wait cycle.
    assign done = (cnt_q <= W'(1));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - single-outstanding AXI3 responder in front of a 1-cycle word SRAM
// Ports: aclk/aresetn (sync, active-low); AR/R, AW/W/B AXI3 channels (4-bit ids, 32-bit data,
//        INCR bursts up to 16 beats); ram_en/ram_wen/ram_addr/ram_wdata/ram_rdata SRAM port.
// Optional: define AXI_RESP_STALL_EN to insert STALL_CYCLES wait cycles before every rvalid/bvalid.
module axi_sram_responder
    import axi_defs::*;
#(
    parameter int RAM_AW       = 16,
    parameter int STALL_CYCLES = 3
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam int HI = RAM_AW + 2;

    function automatic logic out_of_range(input logic [31:0] a);
        return (a >> HI) != 32'd0;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d, beat_q, beat_d;
    logic [2:0]  size_q, size_d;
    logic        dec_q, dec_d, slv_q, slv_d;
    logic        last_rd_q, last_rd_d;
    logic [3:0]  rid_q, rid_d, bid_q, bid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d, bresp_q, bresp_d;
    logic        rlast_q, rlast_d, rvalid_q, rvalid_d, bvalid_q, bvalid_d;
    logic [31:0] next_addr;
    logic        rd_pick;
    logic        last_beat;
    logic        unused_ok;

`ifdef AXI_RESP_STALL_EN
    logic stall_rd_q, stall_rd_d;
    logic stall_load, stall_en, stall_done;

    axi_resp_stall_ctr #(.CYCLES(STALL_CYCLES)) u_stall (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (stall_load),
        .en      (stall_en),
        .done    (stall_done)
    );
`else
    localparam int stall_cycles_unused = STALL_CYCLES;
`endif

    // arlen/awlen upper nibbles and wid carry nothing for a 16-beat, in-order responder.
    assign unused_ok = ^{wid, arlen[7:4], awlen[7:4]};

    assign next_addr = addr_q + (32'd1 << size_q);
    assign last_beat = (beat_q == len_q);
    // With both valids up, serve the channel not served last; reset leaves last_rd_q=0 so read wins.
    assign rd_pick   = arvalid && (!awvalid || !last_rd_q);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        size_d    = size_q;
        dec_d     = dec_q;
        slv_d     = slv_q;
        last_rd_d = last_rd_q;
        rid_d     = rid_q;
        bid_d     = bid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        bresp_d   = bresp_q;
        rlast_d   = rlast_q;
        rvalid_d  = rvalid_q;
        bvalid_d  = bvalid_q;
        arready   = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        ram_en    = 1'b0;
        ram_wen   = 4'b0;
        ram_addr  = '0;
        ram_wdata = 32'd0;
`ifdef AXI_RESP_STALL_EN
        stall_rd_d = stall_rd_q;
        stall_load = 1'b0;
        stall_en   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rd_pick) begin
                    arready   = 1'b1;
                    rid_d     = arid;
                    addr_d    = araddr;
                    len_d     = arlen[3:0];
                    size_d    = arsize;
                    beat_d    = 4'd0;
                    slv_d     = (arburst != AXI_BURST_INCR);
                    dec_d     = out_of_range(araddr);
                    last_rd_d = 1'b1;
                    state_d   = ST_RD_CAP;
                    // First beat's SRAM read is issued in the handshake cycle itself.
                    if (!out_of_range(araddr)) begin
                        ram_en   = 1'b1;
                        ram_addr = araddr[RAM_AW+1:2];
                    end
                end else if (awvalid) begin
                    awready   = 1'b1;
                    bid_d     = awid;
                    addr_d    = awaddr;
                    len_d     = awlen[3:0];
                    size_d    = awsize;
                    beat_d    = 4'd0;
                    slv_d     = (awburst != AXI_BURST_INCR);
                    dec_d     = 1'b0;
                    last_rd_d = 1'b0;
                    state_d   = ST_WR_DATA;
                end
            end
            ST_RD_CAP: begin
                rdata_d = dec_q ? 32'd0 : ram_rdata;
                rresp_d = resp_of(dec_q, slv_q);
                rlast_d = last_beat;
`ifdef AXI_RESP_STALL_EN
                stall_load = 1'b1;
                stall_rd_d = 1'b1;
                state_d    = ST_STALL;
`else
                rvalid_d = 1'b1;
                state_d  = ST_RD_RESP;
`endif
            end
            ST_RD_RESP: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = next_addr;
                        beat_d  = beat_q + 4'd1;
                        dec_d   = out_of_range(next_addr);
                        state_d = ST_RD_CAP;
                        if (!out_of_range(next_addr)) begin
                            ram_en   = 1'b1;
                            ram_addr = next_addr[RAM_AW+1:2];
                        end
                    end
                end
            end
            ST_WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    if (!out_of_range(addr_q)) begin
                        ram_en    = 1'b1;
                        ram_wen   = wstrb;
                        ram_addr  = addr_q[RAM_AW+1:2];
                        ram_wdata = wdata;
                    end
                    dec_d = dec_q | out_of_range(addr_q);
                    // The beat counter decides the burst end; a wlast that disagrees is only flagged.
                    slv_d = slv_q | (wlast != last_beat);
                    if (last_beat) begin
                        bresp_d = resp_of(dec_d, slv_d);
`ifdef AXI_RESP_STALL_EN
                        stall_load = 1'b1;
                        stall_rd_d = 1'b0;
                        state_d    = ST_STALL;
`else
                        bvalid_d = 1'b1;
                        state_d  = ST_WR_RESP;
`endif
                    end else begin
                        addr_d = next_addr;
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            ST_WR_RESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
`ifdef AXI_RESP_STALL_EN
            ST_STALL: begin
                stall_en = 1'b1;
                if (stall_done) begin
                    if (stall_rd_q) begin
                        rvalid_d = 1'b1;
                        state_d  = ST_RD_RESP;
                    end else begin
                        bvalid_d = 1'b1;
                        state_d  = ST_WR_RESP;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'd0;
            len_q     <= 4'd0;
            beat_q    <= 4'd0;
            size_q    <= 3'd0;
            dec_q     <= 1'b0;
            slv_q     <= 1'b0;
            last_rd_q <= 1'b0;
            rid_q     <= 4'd0;
            bid_q     <= 4'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'd0;
            bresp_q   <= 2'd0;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            size_q    <= size_d;
            dec_q     <= dec_d;
            slv_q     <= slv_d;
            last_rd_q <= last_rd_d;
            rid_q     <= rid_d;
            bid_q     <= bid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            bresp_q   <= bresp_d;
            rlast_q   <= rlast_d;
            rvalid_q  <= rvalid_d;
            bvalid_q  <= bvalid_d;
        end
    end

`ifdef AXI_RESP_STALL_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stall_rd_q <= 1'b0;
        end else begin
            stall_rd_q <= stall_rd_d;
        end
    end
`endif

    assign rid    = rid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rlast  = rlast_q;
    assign rvalid = rvalid_q;
    assign bid    = bid_q;
    assign bresp  = bresp_q;
    assign bvalid = bvalid_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// tb/tb_axi_sram_responder.sv - directed + randomized bench against an AXI-level memory model
module tb_axi_sram_responder;
    localparam int RAM_AW = 10;
    localparam int NW     = 1 << RAM_AW;
    localparam logic [31:0] LIM = 32'(4 * NW);
`ifdef AXI_RESP_STALL_EN
    localparam int LAT_R = 5;
    localparam int LAT_B = 4;
`else
    localparam int LAT_R = 2;
    localparam int LAT_B = 1;
`endif

    logic aclk, aresetn;
    logic [3:0] arid, rid, awid, wid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, awsize;
    logic [1:0] arburst, awburst, rresp, bresp;
    logic arvalid, arready, rlast, rvalid, rready;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0] wstrb, ram_wen;
    logic ram_en;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem     [NW];
    logic [31:0] ref_mem [NW];
    int ncmp = 0;
    int nerr = 0;

    axi_sram_responder #(.RAM_AW(RAM_AW), .STALL_CYCLES(3)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Synchronous SRAM: read data appears the cycle after ram_en.
    always @(posedge aclk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        if (a >= LIM) return 32'd0;
        return ref_mem[a[RAM_AW+1:2]];
    endfunction

    function automatic logic [1:0] exp_resp(input logic dec, input logic slv);
        return dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    endfunction

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int hold_beat, input int hold_n);
        logic [31:0] a, d;
        int n;
        arid = id; araddr = addr; arlen = {4'($urandom), len}; arsize = size; arburst = burst;
        arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin @(posedge aclk); #1; n++; end
        check("ar_handshake", {31'd0, arready}, 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!rvalid && n < 20) begin @(posedge aclk); #1; n++; end
            check("r_latency", n, LAT_R - 1);
            check("rdata", rdata, exp_data(a));
            check("rresp", {30'd0, rresp}, {30'd0, exp_resp(a >= LIM, burst != 2'b01)});
            check("rid", {28'd0, rid}, {28'd0, id});
            check("rlast", {31'd0, rlast}, {31'd0, i == int'(len)});
            if (i == hold_beat) begin
                d = rdata;
                repeat (hold_n) begin
                    @(posedge aclk); #1;
                    check("r_hold_valid", {31'd0, rvalid}, 32'd1);
                    check("r_hold_data", rdata, d);
                end
            end
            rready = 1'b1;
            @(posedge aclk); #1;
            rready = 1'b0;
            a = a + (32'd1 << size);
        end
        check("r_done", {31'd0, rvalid}, 32'd0);
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input bit bad_wlast,
                             input bit use_fixed, input logic [31:0] d0, input logic [3:0] s0);
        logic [31:0] a;
        logic dec, slv;
        int n;
        awid = id; awaddr = addr; awlen = {4'($urandom), len}; awsize = size; awburst = burst;
        awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin @(posedge aclk); #1; n++; end
        check("aw_handshake", {31'd0, awready}, 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        a = addr; dec = 1'b0; slv = (burst != 2'b01);
        for (int i = 0; i <= int'(len); i++) begin
            wid   = 4'($urandom);
            wdata = use_fixed ? d0 : $urandom;
            wstrb = use_fixed ? s0 : 4'($urandom);
            wlast = bad_wlast ? (i == 0) : (i == int'(len));
            wvalid = 1'b1;
            #1;
            check("wready", {31'd0, wready}, 32'd1);
            check("ram_en_w", {31'd0, ram_en}, {31'd0, a < LIM});
            if (wlast != (i == int'(len))) slv = 1'b1;
            if (a >= LIM) dec = 1'b1;
            else for (int b = 0; b < 4; b++)
                if (wstrb[b]) ref_mem[a[RAM_AW+1:2]][8*b +: 8] = wdata[8*b +: 8];
            @(posedge aclk); #1;
            a = a + (32'd1 << size);
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge aclk); #1; n++; end
        check("b_latency", n, LAT_B - 1);
        check("bresp", {30'd0, bresp}, {30'd0, exp_resp(dec, slv)});
        check("bid", {28'd0, bid}, {28'd0, id});
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        check("b_done", {31'd0, bvalid}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int n;
        aresetn = 1'b0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        for (int i = 0; i < NW; i++) begin
            v = $urandom;
            mem[i] <= v;
            ref_mem[i] = v;
        end
        mem[32'h40] <= 32'hDEADBEEF;
        ref_mem[32'h40] = 32'hDEADBEEF;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ids", {24'd0, rid, bid}, 32'd0);
        check("rst_resp", {27'd0, rresp, bresp, rlast}, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Simultaneous valids: read wins after reset, then write wins.
        awid = 4'd9; awvalid = 1'b1; arvalid = 1'b1;
        #1;
        check("arb1_arready", {31'd0, arready}, 32'd1);
        check("arb1_awready", {31'd0, awready}, 32'd0);
        axi_read(4'd8, 32'h0000_0200, 4'd0, 3'd2, 2'b01, -1, 0);
        arvalid = 1'b1;
        #1;
        check("arb2_awready", {31'd0, awready}, 32'd1);
        check("arb2_arready", {31'd0, arready}, 32'd0);
        axi_write(4'd9, 32'h0000_0204, 4'd0, 3'd2, 2'b01, 1'b0, 1'b0, 32'd0, 4'd0);
        arvalid = 1'b0;

        axi_read(4'd2, 32'h0000_0100, 4'd0, 3'd2, 2'b01, -1, 0);
        axi_write(4'd5, 32'h0000_0104, 4'd0, 3'd2, 2'b01, 1'b0, 1'b1, 32'h11223344, 4'b0101);
        axi_read(4'd5, 32'h0000_0104, 4'd0, 3'd2, 2'b01, -1, 0);
        axi_read(4'd1, 32'h0000_0FFC, 4'd3, 3'd2, 2'b01, 1, 5);
        axi_write(4'd3, 32'h0000_0300, 4'd1, 3'd2, 2'b01, 1'b1, 1'b0, 32'd0, 4'd0);
        axi_read(4'd3, 32'h0000_0300, 4'd1, 3'd2, 2'b01, -1, 0);
        axi_write(4'd4, 32'h0000_0FF8, 4'd3, 3'd2, 2'b01, 1'b0, 1'b0, 32'd0, 4'd0);
        axi_read(4'd4, 32'h0000_0FF8, 4'd1, 3'd2, 2'b01, -1, 0);
        axi_read(4'd6, 32'h0000_0020, 4'd1, 3'd2, 2'b10, -1, 0);
        axi_write(4'd6, 32'h0000_0040, 4'd0, 3'd2, 2'b00, 1'b0, 1'b0, 32'd0, 4'd0);
        axi_read(4'd7, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01, -1, 0);

        // Reset while a read response is pending drops it.
        arid = 4'd1; araddr = 32'h80; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(posedge aclk); #1; n++; end
        check("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        check("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        for (int t = 0; t < 25; t++) begin
            logic [31:0] a;
            logic [1:0] bu;
            a  = $urandom_range(0, 32'h10FF);
            bu = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01;
            if ($urandom_range(0, 1) == 1)
                axi_write(4'($urandom), a, 4'($urandom), 3'($urandom_range(0, 2)), bu,
                          $urandom_range(0, 5) == 0, 1'b0, 32'd0, 4'd0);
            else
                axi_read(4'($urandom), a, 4'($urandom), 3'($urandom_range(0, 2)), bu,
                         $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
